// File: rtl/text_mem_loader_if.sv
// Byte-stream input and text-memory write port of the boot loader.
// master = loader side, slave = stream source / memory side.
interface text_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_mem_loader.sv
// Boot-time text-memory writer: COUNT byte, N little-endian words, XOR CHECK byte.
// core_hold stays high until a frame loads with a good checksum.

// One byte lane of the word being assembled.
module text_mem_loader_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

module text_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  text_mem_loader_if.master   bus,
  output logic                core_hold,
  output logic                done,
  output logic                err
);
  localparam int         BPW   = DATA_WIDTH / 8;
  localparam int         BIW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [8:0] LIMIT = 9'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE, S_COUNT, S_DATA, S_CHECK, DONE, ERR
  } state_t;

  state_t state_q, state_d;

  logic [7:0]     n_q;
  logic [7:0]     xor_q;
  logic [BIW-1:0] bidx_q;
  logic [8:0]     widx_q;

  logic take_count, take_data, take_check;
  logic last_byte, last_word;

  logic [BPW-1:0][7:0] lane_q;
  logic [BPW-1:0][7:0] word_nxt;

  assign last_byte = (bidx_q == BIW'(BPW - 1));
  assign last_word = ((widx_q + 9'd1) == {1'b0, n_q});

  // Lanes below the current byte already hold their data; the current
  // lane is taken straight from the bus so the word is complete on the
  // same edge its final byte arrives.
  for (genvar i = 0; i < BPW; i++) begin : g_lane
    text_mem_loader_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (take_data && (bidx_q == BIW'(i))),
      .d     (bus.in_data),
      .q     (lane_q[i])
    );
    assign word_nxt[i] = (bidx_q == BIW'(i)) ? bus.in_data : lane_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    take_count   = 1'b0;
    take_data    = 1'b0;
    take_check   = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    core_hold    = 1'b1;
    case (state_q)
      IDLE: if (start) state_d = S_COUNT;
      S_COUNT: begin
        bus.in_ready = 1'b1;
        take_count   = bus.in_valid;
        if (bus.in_valid) begin
          if ({1'b0, bus.in_data} > LIMIT) state_d = ERR;
          else if (bus.in_data == 8'd0)    state_d = S_CHECK;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        bus.in_ready = 1'b1;
        take_data    = bus.in_valid;
        if (bus.in_valid && last_byte && last_word) state_d = S_CHECK;
      end
      S_CHECK: begin
        bus.in_ready = 1'b1;
        take_check   = bus.in_valid;
        if (bus.in_valid) state_d = (bus.in_data == xor_q) ? DONE : ERR;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) state_d = S_COUNT;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_d = S_COUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word counter is one bit wider than the address so N == 2**ADDR_WIDTH
  // can be compared without wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q         <= '0;
      xor_q       <= '0;
      bidx_q      <= '0;
      widx_q      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      if (take_count) begin
        n_q    <= bus.in_data;
        xor_q  <= bus.in_data;
        bidx_q <= '0;
        widx_q <= '0;
      end
      if (take_data) begin
        xor_q  <= xor_q ^ bus.in_data;
        bidx_q <= last_byte ? '0 : bidx_q + BIW'(1);
        if (last_byte) begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= widx_q[ADDR_WIDTH-1:0];
          bus.wr_data <= word_nxt;
          widx_q      <= widx_q + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_mem_loader.sv
// Randomized frame bench for text_mem_loader against a frame-level reference model.
module tb_text_mem_loader;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int BPW = DW / 8;
  localparam int OK  = 1;
  localparam int BAD = 2;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_hold, done, err;

  int n_chk = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] cap_q[$];
  logic [AW+DW-1:0] exp_q[$];
  int exp_res;

  text_mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  text_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus.master),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.wr_en) cap_q.push_back({bus.wr_addr, bus.wr_data});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (!bus.in_ready) chk("rdy_timeout", 0, 1);
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  // Reference: decode the frame by its rules into expected writes and outcome.
  task automatic model(input bq_t f);
    int n;
    logic [7:0] x;
    logic [DW-1:0] w;
    exp_q.delete();
    n = f[0];
    if (n > (1 << AW)) begin
      exp_res = BAD;
      return;
    end
    x = f[0];
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) begin
        w = w | (DW'(f[1 + k*BPW + b]) << (8*b));
        x = x ^ f[1 + k*BPW + b];
      end
      exp_q.push_back({AW'(k), w});
    end
    exp_res = (f[1 + n*BPW] == x) ? OK : BAD;
  endtask

  task automatic make_frame(input int n, input bit bad, output bq_t f);
    logic [7:0] x, b;
    f.delete();
    f.push_back(8'(n));
    if (n <= (1 << AW)) begin
      x = 8'(n);
      for (int i = 0; i < n*BPW; i++) begin
        b = 8'($urandom);
        f.push_back(b);
        x = x ^ b;
      end
      f.push_back(bad ? x ^ 8'($urandom_range(1, 255)) : x);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nwr"}, cap_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < cap_q.size()) chk({tag, "_wr"}, cap_q[i], exp_q[i]);
    chk({tag, "_done"}, done, exp_res == OK);
    chk({tag, "_err"}, err, exp_res == BAD);
    chk({tag, "_hold"}, core_hold, exp_res != OK);
    chk({tag, "_rdy"}, bus.in_ready, 0);
    if (exp_q.size() > 0) chk({tag, "_bus_hold"}, {bus.wr_addr, bus.wr_data}, exp_q[$]);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int gmin, input int gmax,
                           input bit overlap);
    cap_q.delete();
    model(f);
    if (overlap) begin
      bus.in_valid = 1'b1;
      bus.in_data  = f[0];
    end
    pulse_start();
    for (int i = 0; i < f.size(); i++) begin
      if (i > 0) begin
        // stray start pulses mid-frame must be ignored
        repeat ($urandom_range(gmin, gmax)) begin
          start = ($urandom_range(0, 3) == 0);
          tick(1);
        end
        start = 1'b0;
      end
      put_byte(f[i]);
      if (i == 0 && f.size() > 1) begin
        chk({tag, "_hold_mid"}, core_hold, 1);
        chk({tag, "_done_mid"}, done, 0);
      end
      if (i == 0 && f.size() == 1) chk({tag, "_ovf_next"}, err, 1);
    end
    tick(2);
    compare(tag);
  endtask

  initial begin
    bq_t t2, t3, f;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    t2 = '{8'h02, 8'h03, 8'h25, 8'h05, 8'h00, 8'h83, 8'hA5, 8'h45, 8'h00, 8'h42};

    // reset
    rst_n = 1'b0;
    tick(2);
    chk("rst_hold", core_hold, 1);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_wren", bus.wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_data", bus.wr_data, 0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_rdy", bus.in_ready, 0);

    // known good frame, also pinned to literal words
    run_frame("t2", t2, 0, 0, 1'b0);
    chk("t2_w0", cap_q.size() > 0 ? cap_q[0] : '0, {4'd0, 32'h00052503});
    chk("t2_w1", cap_q.size() > 1 ? cap_q[1] : '0, {4'd1, 32'h0045A583});

    // bad checksum, then recovery
    t3 = t2;
    t3[9] = 8'h43;
    run_frame("t3", t3, 0, 0, 1'b0);
    run_frame("t3b", t2, 0, 0, 1'b1);

    // zero length
    run_frame("t4", '{8'h00, 8'h00}, 0, 0, 1'b0);

    // gapped frame
    run_frame("t5", t2, 3, 3, 1'b0);

    // reset after the 6th byte
    cap_q.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(3);
      put_byte(t2[i]);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t5r_rdy", bus.in_ready, 0);
    chk("t5r_hold", core_hold, 1);
    chk("t5r_done", done, 0);
    chk("t5r_addr", bus.wr_addr, 0);
    tick(3);
    chk("t5r_nwr", cap_q.size(), 1);
    chk("t5r_w0", cap_q.size() > 0 ? cap_q[0] : '0, {4'd0, 32'h00052503});
    chk("t5r_idle_rdy", bus.in_ready, 0);

    // size boundary
    make_frame(17, 1'b0, f);
    run_frame("t6_ovf", f, 0, 0, 1'b0);
    make_frame(16, 1'b0, f);
    run_frame("t6_max", f, 0, 0, 1'b0);

    // randomized frames
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) n = $urandom_range(17, 255);
      else                           n = $urandom_range(0, 16);
      make_frame(n, $urandom_range(0, 3) == 0, f);
      run_frame("rnd", f, 0, 2, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
